// File: rtl/sw_req_pkg.sv
// sw_req_pkg: shared debounce FSM encoding and default debounce length
package sw_req_pkg;
    typedef enum logic [1:0] {
        LO     = 2'd0,
        CHK_HI = 2'd1,
        HI     = 2'd2,
        CHK_LO = 2'd3
    } db_state_t;
    localparam int DB_CYCLES_DEF = 16;
endpackage

// File: rtl/sw_debounce_bit.sv
// sw_debounce_bit: 2-flop synchroniser plus debounce FSM for one switch
//   clk, rst_n : clock, async active-low reset
//   sw_raw     : raw asynchronous switch level
//   db_level   : debounced level
//   rise       : one-cycle pulse on the edge where db_level goes 0->1
module sw_debounce_bit
    import sw_req_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_raw,
    output logic db_level,
    output logic rise
);
    localparam int CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
    logic s1, s2;
    db_state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic done;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            state <= LO;
            cnt   <= '0;
        end else begin
            s1    <= sw_raw;
            s2    <= s1;
            state <= state_n;
            cnt   <= cnt_n;
        end
    assign done = cnt == CNT_LAST;
    // The first differing sample already counts as 1, so the level flips on
    // the DB_CYCLES-th consecutive differing sample.
    always_comb begin
        state_n = state;
        cnt_n   = '0;
        rise    = 1'b0;
        case (state)
            LO:     if (s2) begin state_n = CHK_HI; cnt_n = CW'(1); end
            CHK_HI: if (!s2) state_n = LO;
                    else if (done) begin state_n = HI; rise = 1'b1; end
                    else cnt_n = cnt + CW'(1);
            HI:     if (!s2) begin state_n = CHK_LO; cnt_n = CW'(1); end
            CHK_LO: if (s2) state_n = HI;
                    else if (done) state_n = LO;
                    else cnt_n = cnt + CW'(1);
            default: state_n = LO;
        endcase
    end
    // Rise is combinational so pend sets on the same edge db_level does.
    assign db_level = state == HI || state == CHK_LO;
endmodule

// File: rtl/sw_req_capture.sv
// sw_req_capture: debounced switches to sticky pending requests with indexed ack
//   clk, rst_n : clock, async active-low reset
//   sw_raw     : N raw switch levels
//   ack/ack_idx: clear one pending request (encoder O echo)
//   clr_all    : clear all requests and overflow
//   pend       : sticky requests (encoder I); pend_any = |pend
//   db_level   : debounced switch levels
//   overflow   : sticky, a rise hit an already pending bit
//   ack_err    : pulse, ack hit a non-pending bit
module sw_req_capture
    import sw_req_pkg::*;
#(
    parameter  int N         = 8,
    parameter  int DB_CYCLES = DB_CYCLES_DEF,
    localparam int IDX_W     = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     sw_raw,
    input  logic             ack,
    input  logic [IDX_W-1:0] ack_idx,
    input  logic             clr_all,
    output logic [N-1:0]     pend,
    output logic             pend_any,
    output logic [N-1:0]     db_level,
    output logic             overflow,
    output logic             ack_err
);
    logic [N-1:0] rise, ack_vec;
    for (genvar i = 0; i < N; i++) begin : g_db
        sw_debounce_bit #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clk      (clk),
            .rst_n    (rst_n),
            .sw_raw   (sw_raw[i]),
            .db_level (db_level[i]),
            .rise     (rise[i])
        );
    end
    assign ack_vec  = ack ? {{(N-1){1'b0}}, 1'b1} << ack_idx : '0;
    assign pend_any = |pend;
    // A rise always wins over a same-cycle clear; an ack on the rising bit
    // consumes the old request, so that case is not an overflow.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            pend     <= '0;
            overflow <= 1'b0;
            ack_err  <= 1'b0;
        end else begin
            pend     <= rise | (clr_all ? '0 : pend & ~ack_vec);
            overflow <= (|(rise & pend & ~ack_vec)) | (overflow & ~clr_all);
            ack_err  <= ack & ~pend[ack_idx] & ~clr_all;
        end
endmodule

// File: tb/tb_sw_req_capture.sv
// tb_sw_req_capture: scoreboard bench for sw_req_capture against a run-length model
module tb_sw_req_capture;
    localparam int N  = 8;
    localparam int DB = 4;
    logic       clk = 1'b0, rst_n = 1'b0, ack = 1'b0, clr_all = 1'b0;
    logic [7:0] sw_raw = 8'h00;
    logic [2:0] ack_idx = 3'd0;
    logic [7:0] pend, db_level;
    logic       pend_any, overflow, ack_err;
    typedef struct {
        logic [7:0] pend;
        logic [7:0] db;
        logic       ovf;
        logic       aerr;
    } exp_t;
    exp_t       q[$];
    bit   [7:0] hist[$];
    bit   [7:0] m_lvl, m_pend;
    bit         m_ovf;
    int         m_run[N];
    int         compared = 0, mismatched = 0;

    always #5 clk = ~clk;

    sw_req_capture #(.N(N), .DB_CYCLES(DB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sw_raw   (sw_raw),
        .ack      (ack),
        .ack_idx  (ack_idx),
        .clr_all  (clr_all),
        .pend     (pend),
        .pend_any (pend_any),
        .db_level (db_level),
        .overflow (overflow),
        .ack_err  (ack_err)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        m_lvl  = '0;
        m_pend = '0;
        m_ovf  = 1'b0;
        foreach (m_run[i]) m_run[i] = 0;
    endtask

    // A level is accepted once DB consecutive synchronised samples disagree
    // with it; samples reach the debouncer two clocks after sw_raw.
    task automatic model_edge();
        bit [7:0] s, rise;
        exp_t e;
        s = '0;
        rise = '0;
        hist.push_back(sw_raw);
        if (hist.size() > 2) s = hist.pop_front();
        for (int i = 0; i < N; i++) begin
            if (s[i] == m_lvl[i]) m_run[i] = 0;
            else begin
                m_run[i] = m_run[i] + 1;
                if (m_run[i] == DB) begin
                    m_lvl[i] = s[i];
                    m_run[i] = 0;
                    rise[i]  = s[i];
                end
            end
        end
        e.aerr = ack && !m_pend[ack_idx] && !clr_all;
        e.ovf  = m_ovf && !clr_all;
        for (int i = 0; i < N; i++) begin
            bit acked;
            acked = ack && ack_idx == i;
            if (rise[i]) begin
                if (m_pend[i] && !acked) e.ovf = 1'b1;
                m_pend[i] = 1'b1;
            end else if (clr_all || acked) m_pend[i] = 1'b0;
        end
        m_ovf  = e.ovf;
        e.pend = m_pend;
        e.db   = m_lvl;
        q.push_back(e);
    endtask

    task automatic step(input logic [7:0] s, input logic a = 1'b0,
                        input logic [2:0] ai = 3'd0, input logic c = 1'b0);
        sw_raw  = s;
        ack     = a;
        ack_idx = ai;
        clr_all = c;
        @(posedge clk);
        model_edge();
        #1;
        ack     = 1'b0;
        clr_all = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(sw_raw);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_pend"}, pend, 8'h00);
        check({tag, "_db"}, db_level, 8'h00);
        check({tag, "_any"}, {7'd0, pend_any}, 8'h00);
        check({tag, "_ovf"}, {7'd0, overflow}, 8'h00);
        check({tag, "_aerr"}, {7'd0, ack_err}, 8'h00);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("pend", pend, e.pend);
                check("pend_any", {7'd0, pend_any}, {7'd0, |e.pend});
                check("db_level", db_level, e.db);
                check("overflow", {7'd0, overflow}, {7'd0, e.ovf});
                check("ack_err", {7'd0, ack_err}, {7'd0, e.aerr});
            end
        end
    end

    initial begin
        logic [7:0] s;
        logic [2:0] ai;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        // quiet inputs
        step(8'h00); idle(19);
        // bit 5 press, latency, ack
        step(8'h20); idle(7);
        step(8'h20, 1'b1, 3'd5); idle(2);
        step(8'h00); idle(7);
        // 3-cycle glitch rejected, 4-cycle pulse accepted
        step(8'h04); idle(2);
        step(8'h00); idle(8);
        step(8'h04); idle(3);
        step(8'h00); idle(8);
        // overflow on re-press without ack, then clr_all
        step(8'h00, 1'b0, 3'd0, 1'b1);
        step(8'h01); idle(7);
        step(8'h00); idle(7);
        step(8'h01); idle(7);
        step(8'h01, 1'b0, 3'd0, 1'b1); idle(2);
        step(8'h00); idle(7);
        // rise coinciding with ack of the same bit; ack of a non-pending bit
        step(8'h08); idle(4);
        step(8'h08, 1'b1, 3'd3); idle(2);
        step(8'h08, 1'b1, 3'd6); idle(2);
        // async reset mid CHK_HI on bit 7
        step(8'h00, 1'b0, 3'd0, 1'b1); idle(8);
        step(8'h10); idle(7);
        step(8'h90); idle(2);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        idle(8);
        // randomized traffic
        repeat (400) begin
            s = sw_raw;
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 11) == 0) s[b] = ~s[b];
            ai = 3'($urandom_range(0, 7));
            if (m_pend != 0 && $urandom_range(0, 1) == 1)
                while (!m_pend[ai]) ai = ai + 3'd1;
            step(s, $urandom_range(0, 3) == 0, ai, $urandom_range(0, 39) == 0);
        end
        idle(2);
        @(negedge clk);
        #1;
        check("drain", 8'(q.size()), 8'h00);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
